flopr_skid: RTL and testbench

- 64-bit pipeline register with a valid/ready handshake on both sides, built as a 2-entry skid buffer.
- Sits between processor pipeline stages as the stallable replacement for a bare `flopr`.
- The write side accepts data; the read side presents it and holds it stable until the consumer takes it.
- Full throughput (one transfer per cycle) with a registered output path; `in_ready` does not depend on `out_ready` combinationally.

---
 rtl/flopr_skid_if.sv | 33 +++
 rtl/flopr_skid.sv | 83 ++++++++
 tb/tb_flopr_skid.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/flopr_skid_if.sv
// Valid/ready handshake bundle for the flopr_skid pipeline register.
// The producer/consumer side uses master; the register itself uses slave.
interface flopr_skid_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   occupancy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );
endinterface

// File: rtl/flopr_skid.sv
// Stallable 2-entry skid-buffer pipeline register with a registered output.
// state | meaning
// EMPTY | no word held, out_valid low
// ONE   | main holds the head word
// FULL  | main holds head, skid holds the next word, in_ready low
module flopr_skid #(
    parameter int N = 64
) (
    input  logic        clk,
    input  logic        reset,
    flopr_skid_if.slave bus
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [N-1:0] main_q,  main_d;
    logic [N-1:0] skid_q,  skid_d;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;

    // in_ready is a function of state (and reset) only, never of out_ready.
    assign in_ready  = reset & (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    main_d  = bus.in_data;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = bus.in_data;
                end else if (in_fire) begin
                    skid_d  = bus.in_data;
                    state_d = S_FULL;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign bus.occupancy = state_q;

endmodule

// File: tb/tb_flopr_skid.sv
// Directed bench for flopr_skid: a queue model checked every cycle plus literal expectations.
`timescale 1ns/100ps
module tb_flopr_skid;

    localparam int N = 64;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    flopr_skid_if #(.N(N)) bus ();

    flopr_skid #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two words; when empty, out_data shows the
    // last word that left (or zero after reset).
    logic [N-1:0] mq[$];
    logic [N-1:0] hold_val = '0;
    logic         m_in_fire, m_out_fire;
    int           out_seen = 0;

    always @(negedge reset) begin
        mq.delete();
        hold_val = '0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_in_fire  = bus.in_valid && (mq.size() < 2);
            m_out_fire = (mq.size() > 0) && bus.out_ready;
            if (bus.out_valid && bus.out_ready) out_seen++;
            if (m_out_fire) hold_val = mq.pop_front();
            if (m_in_fire) mq.push_back(bus.in_data);
        end
    end

    always @(negedge clk) begin
        chk("occupancy", 64'(bus.occupancy), 64'(mq.size()));
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        chk("in_ready",  64'(bus.in_ready),  64'(reset && (mq.size() < 2)));
        chk("out_data",  bus.out_data, (mq.size() != 0) ? mq[0] : hold_val);
        chk("no_x", 64'($isunknown({bus.out_data, bus.out_valid, bus.in_ready, bus.occupancy})), 64'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [63:0] words [10];

    initial begin
        words[0] = 64'h2A3BCD4E2A3BCD4E;
        words[1] = 64'h0000000000000001;
        words[2] = 64'h8000000000000000;
        words[3] = 64'h5555555555555555;
        words[4] = 64'hAAAAAAAAAAAAAAAA;
        words[5] = 64'h0123456789ABCDEF;
        words[6] = 64'hFEDCBA9876543210;
        words[7] = 64'h00000000FFFFFFFF;
        words[8] = 64'hFFFFFFFF00000000;
        words[9] = 64'hFFFFFFFFFFFFFFFF;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // 1: reset held with a word offered
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h2A3BCD4E2A3BCD4E;
        #50;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  bus.out_data, 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rel_in_ready",  64'(bus.in_ready), 64'd1);
        chk("rel_occupancy", 64'(bus.occupancy), 64'd0);
        @(posedge clk);
        #2;

        // 2: streaming
        out_seen = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = words[i];
            cyc();
            chk("stream_data", bus.out_data, words[i]);
            chk("stream_occ",  64'(bus.occupancy), 64'd1);
            chk("stream_rdy",  64'(bus.in_ready), 64'd1);
        end
        bus.in_valid = 1'b0;
        cyc();
        chk("stream_count", 64'(out_seen), 64'd10);
        chk("stream_empty", 64'(bus.out_valid), 64'd0);

        // 3: backpressure
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hCAFEBABECAFEBABE;
        cyc();
        chk("bp_occ1", 64'(bus.occupancy), 64'd1);
        bus.in_data = 64'hBADC0FFEBADC0FFE;
        cyc();
        chk("bp_occ2",   64'(bus.occupancy), 64'd2);
        chk("bp_rdy0",   64'(bus.in_ready), 64'd0);
        chk("bp_hold",   bus.out_data, 64'hCAFEBABECAFEBABE);
        bus.in_data = 64'h3333333333333333;
        cyc();
        cyc();
        chk("bp_refuse_occ",  64'(bus.occupancy), 64'd2);
        chk("bp_refuse_data", bus.out_data, 64'hCAFEBABECAFEBABE);
        bus.out_ready = 1'b1;
        cyc();
        chk("bp_second", bus.out_data, 64'hBADC0FFEBADC0FFE);
        chk("bp_occ_after", 64'(bus.occupancy), 64'd1);
        cyc();
        chk("bp_third", bus.out_data, 64'h3333333333333333);
        bus.in_valid = 1'b0;
        cyc();
        chk("bp_drained", 64'(bus.occupancy), 64'd0);

        // 4: full drain with no new input
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h1111111111111111;
        cyc();
        bus.in_data   = 64'h2222222222222222;
        cyc();
        chk("drain_occ2", 64'(bus.occupancy), 64'd2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        chk("drain_occ1",  64'(bus.occupancy), 64'd1);
        chk("drain_data2", bus.out_data, 64'h2222222222222222);
        cyc();
        chk("drain_occ0",  64'(bus.occupancy), 64'd0);
        chk("drain_valid", 64'(bus.out_valid), 64'd0);

        // 5: async reset mid-operation
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h4444444444444444;
        cyc();
        bus.in_data   = 64'h5555555555555555;
        cyc();
        bus.in_valid  = 1'b0;
        chk("ar_occ2", 64'(bus.occupancy), 64'd2);
        #1 reset = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.out_valid), 64'd0);
        chk("ar_occ",   64'(bus.occupancy), 64'd0);
        chk("ar_data",  bus.out_data, 64'd0);
        #1 reset = 1'b1;
        #1;
        chk("ar_rdy", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h1234567812345678;
        cyc();
        chk("ar_word", bus.out_data, 64'h1234567812345678);
        chk("ar_occ1", 64'(bus.occupancy), 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        chk("ar_no_stale", 64'(bus.occupancy), 64'd0);

        // 6: X isolation
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("x_idle_occ", 64'(bus.occupancy), 64'd0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h0;
        cyc();
        bus.in_valid = 1'b0;
        chk("x_zero_data",  bus.out_data, 64'h0000000000000000);
        chk("x_zero_valid", 64'(bus.out_valid), 64'd1);
        chk("x_clean", 64'($isunknown({bus.out_data, bus.out_valid, bus.occupancy})), 64'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
